// File: rtl/decode_seq_pkg.sv
// Shared definitions for the decode_seq instruction sequencer: state and opcode
// enums, accumulator-source encodings, the NOP constant and the decoded-field record.
package decode_seq_pkg;

   localparam int PC_W   = 8;
   localparam int INST_W = 9;
   localparam int ARG_W  = 5;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
   } Seq_State;

   typedef enum logic [2:0] {
      SUB_NOP, SUB_LDI, SUB_MOVA, SUB_LD, SUB_ST, SUB_BZ, SUB_JMP, SUB_HALT
   } Sub_Ops;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_PASS
   } ALU_Ops;

   localparam logic [1:0] ACC_SEL_ALU = 2'd0;
   localparam logic [1:0] ACC_SEL_IMM = 2'd1;
   localparam logic [1:0] ACC_SEL_MEM = 2'd2;

   localparam logic [INST_W-1:0] NOP_INST = {1'b1, SUB_NOP, 5'd0};

   typedef struct packed {
      ALU_Ops          op;
      logic [4:0]      rf_addr;
      logic [PC_W-1:0] imm;
      logic [1:0]      acc_sel;
      logic            acc_wr;
      logic            rf_wr;
      logic            is_mem;
      logic            is_st;
      logic            is_bz;
      logic            is_jmp;
      logic            is_halt;
      logic [PC_W-1:0] offs;
   } Dec_Fields;

   function automatic logic [PC_W-1:0] sext_arg(input logic [ARG_W-1:0] a);
      return {{(PC_W-ARG_W){a[ARG_W-1]}}, a};
   endfunction

endpackage

// File: rtl/decode_seq_if.sv
// Instruction- and data-memory handshake bundle; master is the sequencer side.
interface decode_seq_if;
   import decode_seq_pkg::*;

   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack;
   logic [INST_W-1:0] imem_data;
   logic              dmem_req;
   logic              dmem_we;
   logic              dmem_ack;

   modport master (output imem_req, imem_addr, dmem_req, dmem_we,
                   input  imem_ack, imem_data, dmem_ack);
   modport slave  (input  imem_req, imem_addr, dmem_req, dmem_we,
                   output imem_ack, imem_data, dmem_ack);
endinterface

// File: rtl/decode_seq_inst_decode.sv
// Purely combinational split of a 9-bit instruction into datapath control fields.
module inst_decode
   import decode_seq_pkg::*;
(
   input  logic [INST_W-1:0] i_inst,
   output Dec_Fields         o_dec
);

   logic [ARG_W-1:0] w_arg;
   assign w_arg = i_inst[ARG_W-1:0];

   always_comb begin
      o_dec = '0;
      if (!i_inst[8]) begin
         o_dec.op      = ALU_Ops'(i_inst[7:5]);
         o_dec.rf_addr = w_arg;
         o_dec.acc_wr  = 1'b1;
         o_dec.acc_sel = ACC_SEL_ALU;
      end else begin
         case (Sub_Ops'(i_inst[7:5]))
            SUB_LDI: begin
               o_dec.imm     = {{(PC_W-ARG_W){1'b0}}, w_arg};
               o_dec.acc_wr  = 1'b1;
               o_dec.acc_sel = ACC_SEL_IMM;
            end
            SUB_MOVA: begin
               o_dec.rf_addr = w_arg;
               o_dec.rf_wr   = 1'b1;
            end
            SUB_LD: begin
               o_dec.rf_addr = w_arg;
               o_dec.is_mem  = 1'b1;
               o_dec.acc_sel = ACC_SEL_MEM;
            end
            SUB_ST: begin
               o_dec.rf_addr = w_arg;
               o_dec.is_mem  = 1'b1;
               o_dec.is_st   = 1'b1;
            end
            SUB_BZ: begin
               o_dec.is_bz = 1'b1;
               o_dec.offs  = sext_arg(w_arg);
            end
            SUB_JMP: begin
               o_dec.is_jmp = 1'b1;
               o_dec.offs   = sext_arg(w_arg);
            end
            SUB_HALT: o_dec.is_halt = 1'b1;
            default:  ;
         endcase
      end
   end

endmodule

// File: rtl/decode_seq.sv
// decode_seq: FETCH/DECODE/EXEC/MEM sequencer driving an accumulator datapath.
// Define CYCLE_COUNT_EN to build the saturating busy-cycle counter on cycle_cnt.
module decode_seq
   import decode_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   decode_seq_if.master      bus,
   input  logic [PC_W-1:0]   acc_in,
   output logic [2:0]        op_ctrl,
   output logic [4:0]        rf_addr,
   output logic              rf_we,
   output logic              acc_we,
   output logic [1:0]        acc_sel,
   output logic [PC_W-1:0]   imm_out,
   output logic [PC_W-1:0]   pc,
   output logic              halted,
   output logic [CNT_W-1:0]  cycle_cnt
);

   Seq_State          r_state;
   logic [PC_W-1:0]   r_pc;
   logic              r_halted;
   logic [INST_W-1:0] r_inst;
   logic              r_imem_req, r_dmem_req, r_dmem_we;
   logic              r_acc_we, r_rf_we;
   ALU_Ops            r_op;
   logic [4:0]        r_rf_addr;
   logic [1:0]        r_acc_sel;
   logic [PC_W-1:0]   r_imm, r_offs;
   logic              r_is_mem, r_is_st, r_is_bz, r_is_jmp, r_is_halt;

   Dec_Fields         w_dec;
   logic              w_take;
   logic [PC_W-1:0]   w_pc_next;

   inst_decode u_dec (.i_inst(r_inst), .o_dec(w_dec));

   assign w_take    = r_is_jmp | (r_is_bz & (acc_in == '0));
   assign w_pc_next = w_take ? r_pc + r_offs : r_pc + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_halted   <= 1'b0;
         r_inst     <= NOP_INST;
         r_imem_req <= 1'b0;
         r_dmem_req <= 1'b0;
         r_dmem_we  <= 1'b0;
         r_acc_we   <= 1'b0;
         r_rf_we    <= 1'b0;
         r_op       <= ALU_ADD;
         r_rf_addr  <= '0;
         r_acc_sel  <= '0;
         r_imm      <= '0;
         r_offs     <= '0;
         r_is_mem   <= 1'b0;
         r_is_st    <= 1'b0;
         r_is_bz    <= 1'b0;
         r_is_jmp   <= 1'b0;
         r_is_halt  <= 1'b0;
      end else begin
         r_acc_we <= 1'b0;
         r_rf_we  <= 1'b0;
         case (r_state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  r_state    <= S_FETCH;
                  r_pc       <= '0;
                  r_halted   <= 1'b0;
                  r_imem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               if (bus.imem_ack) begin
                  r_inst     <= bus.imem_data;
                  r_imem_req <= 1'b0;
                  r_state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_op      <= w_dec.op;
               r_rf_addr <= w_dec.rf_addr;
               r_imm     <= w_dec.imm;
               r_acc_sel <= w_dec.acc_sel;
               r_offs    <= w_dec.offs;
               r_is_mem  <= w_dec.is_mem;
               r_is_st   <= w_dec.is_st;
               r_is_bz   <= w_dec.is_bz;
               r_is_jmp  <= w_dec.is_jmp;
               r_is_halt <= w_dec.is_halt;
               r_acc_we  <= w_dec.acc_wr;
               r_rf_we   <= w_dec.rf_wr;
               r_state   <= S_EXEC;
            end
            S_EXEC: begin
               if (r_is_halt) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end else if (r_is_mem) begin
                  r_state    <= S_MEM;
                  r_dmem_req <= 1'b1;
                  r_dmem_we  <= r_is_st;
               end else begin
                  r_pc       <= w_pc_next;
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
               end
            end
            S_MEM: begin
               if (bus.dmem_ack) begin
                  r_dmem_req <= 1'b0;
                  r_dmem_we  <= 1'b0;
                  r_pc       <= r_pc + 1'b1;
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A load writes the accumulator in the very cycle the data memory acknowledges.
   assign acc_we        = r_acc_we | ((r_state == S_MEM) & r_is_mem & ~r_is_st & bus.dmem_ack);
   assign rf_we         = r_rf_we;
   assign op_ctrl       = r_op;
   assign rf_addr       = r_rf_addr;
   assign acc_sel       = r_acc_sel;
   assign imm_out       = r_imm;
   assign pc            = r_pc;
   assign halted        = r_halted;
   assign bus.imem_req  = r_imem_req;
   assign bus.imem_addr = r_pc;
   assign bus.dmem_req  = r_dmem_req;
   assign bus.dmem_we   = r_dmem_we;

`ifdef CYCLE_COUNT_EN
   logic [CNT_W-1:0] r_cycle_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle_cnt <= '0;
      end else if (r_state == S_IDLE || r_state == S_HALT) begin
         if (start) r_cycle_cnt <= '0;
      end else if (r_cycle_cnt != '1) begin
         r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
`else
   assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: vector table, directed multi-cycle sequences and random
// programs checked against an instruction-level interpreter.
module tb_decode_seq;
   import decode_seq_pkg::*;

   localparam int LIMIT = 30;
`ifdef CYCLE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, start;
   logic [7:0]  acc_in;
   logic [2:0]  op_ctrl;
   logic [4:0]  rf_addr;
   logic        rf_we, acc_we, halted;
   logic [1:0]  acc_sel;
   logic [7:0]  imm_out, pc;
   logic [15:0] cycle_cnt;

   decode_seq_if bus();

   decode_seq dut (.clk(clk), .reset(reset), .start(start), .bus(bus), .acc_in(acc_in),
                   .op_ctrl(op_ctrl), .rf_addr(rf_addr), .rf_we(rf_we), .acc_we(acc_we),
                   .acc_sel(acc_sel), .imm_out(imm_out), .pc(pc), .halted(halted),
                   .cycle_cnt(cycle_cnt));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [8:0] imem [256];
   int imem_delay, dmem_delay, iw, dw;
   bit spur;

   typedef struct packed {
      logic [7:0] addr;
      logic [3:0] nacc;
      logic [1:0] sel;
      logic [7:0] pay;
      logic [3:0] nrf;
      logic [3:0] nld;
      logic [3:0] nst;
   } rec_t;
   rec_t exp_q[$];
   rec_t cur;

   typedef struct {
      string      name;
      logic [8:0] inst;
      logic [7:0] acc;
      logic       acc_we;
      logic [1:0] sel;
      logic       rf_we;
      int         kind;   // 0 none, 1 imm_out, 2 {op_ctrl,rf_addr}, 3 rf_addr
      logic [7:0] val;
      logic [7:0] pc_nx;
   } vec_t;
   vec_t vt[12];

   function automatic logic [8:0] sop(input int s, input int a);
      return {1'b1, 3'(s), 5'(a)};
   endfunction
   function automatic logic [8:0] alu(input int o, input int r);
      return {1'b0, 3'(o), 5'(r)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory responder: ack after the configured number of wait cycles.
   task automatic cycle();
      @(posedge clk);
      #2;
      if (bus.imem_req) begin
         if (iw >= imem_delay) begin
            bus.imem_ack = 1'b1; bus.imem_data = imem[bus.imem_addr]; iw = 0;
         end else begin
            bus.imem_ack = 1'b0; iw++;
         end
      end else begin
         bus.imem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.imem_data = 9'($urandom);
         iw = 0;
      end
      if (bus.dmem_req) begin
         if (dw >= dmem_delay) begin bus.dmem_ack = 1'b1; dw = 0; end
         else begin bus.dmem_ack = 1'b0; dw++; end
      end else begin
         bus.dmem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
         dw = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; spur = 1'b0;
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_data = NOP_INST;
      iw = 0; dw = 0; imem_delay = 0; dmem_delay = 0; acc_in = 8'h00;
      cycle(); cycle();
      reset = 1'b0;
      cycle();
   endtask

   task automatic pulse_start();
      start = 1'b1; cycle(); start = 1'b0;
   endtask

   task automatic fill_halt();
      for (int a = 0; a < 256; a++) imem[a] = sop(7, 0);
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Instruction-level interpreter: one record per executed instruction.
   function automatic void model(input logic [7:0] acc);
      logic [7:0] mpc;
      logic [8:0] ins;
      logic [4:0] arg;
      int offs;
      bit done;
      rec_t r;
      mpc = 8'd0; done = 1'b0;
      exp_q.delete();
      for (int k = 0; k < LIMIT && !done; k++) begin
         ins = imem[mpc]; arg = ins[4:0];
         offs = arg[4] ? int'(arg) - 32 : int'(arg);
         r = '0; r.addr = mpc;
         if (!ins[8]) begin
            r.nacc = 1; r.sel = 2'd0; r.pay = ins[7:0]; mpc = mpc + 8'd1;
         end else begin
            case (ins[7:5])
               3'd1: begin r.nacc = 1; r.sel = 2'd1; r.pay = {3'b0, arg}; mpc = mpc + 8'd1; end
               3'd2: begin r.nrf = 1; r.pay = {3'b0, arg}; mpc = mpc + 8'd1; end
               3'd3: begin r.nacc = 1; r.sel = 2'd2; r.pay = {3'b0, arg}; r.nld = 1; mpc = mpc + 8'd1; end
               3'd4: begin r.nst = 1; mpc = mpc + 8'd1; end
               3'd5: mpc = (acc == 8'd0) ? 8'(int'(mpc) + offs + 256) : mpc + 8'd1;
               3'd6: mpc = 8'(int'(mpc) + offs + 256);
               3'd7: done = 1'b1;
               default: mpc = mpc + 8'd1;
            endcase
         end
         exp_q.push_back(r);
      end
   endfunction

   initial begin
      int nobs, nreq;
      bit open, timed_out;

      reset = 1'b1; start = 1'b0; spur = 1'b0; acc_in = 8'h00;
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_data = NOP_INST;
      iw = 0; dw = 0; imem_delay = 0; dmem_delay = 0;
      fill_halt();

      vt[0]  = '{"alu_add_r3", alu(0, 3),   8'h00, 1'b1, 2'd1 - 2'd1, 1'b0, 2, {3'd0, 5'd3},  8'd1};
      vt[1]  = '{"alu_op7_r31", alu(7, 31), 8'h00, 1'b1, 2'd0, 1'b0, 2, {3'd7, 5'd31}, 8'd1};
      vt[2]  = '{"ldi_5",      sop(1, 5),   8'h00, 1'b1, 2'd1, 1'b0, 1, 8'd5,  8'd1};
      vt[3]  = '{"ldi_31",     sop(1, 31),  8'h00, 1'b1, 2'd1, 1'b0, 1, 8'd31, 8'd1};
      vt[4]  = '{"mova_r9",    sop(2, 9),   8'h00, 1'b0, 2'd0, 1'b1, 3, 8'd9,  8'd1};
      vt[5]  = '{"nop",        sop(0, 21),  8'h00, 1'b0, 2'd0, 1'b0, 0, 8'd0,  8'd1};
      vt[6]  = '{"bz_m2_taken", sop(5, 30), 8'h00, 1'b0, 2'd0, 1'b0, 0, 8'd0,  8'd254};
      vt[7]  = '{"bz_m2_not",  sop(5, 30),  8'h01, 1'b0, 2'd0, 1'b0, 0, 8'd0,  8'd1};
      vt[8]  = '{"bz_p15",     sop(5, 15),  8'h00, 1'b0, 2'd0, 1'b0, 0, 8'd0,  8'd15};
      vt[9]  = '{"jmp_m1",     sop(6, 31),  8'h07, 1'b0, 2'd0, 1'b0, 0, 8'd0,  8'd255};
      vt[10] = '{"jmp_m16",    sop(6, 16),  8'h00, 1'b0, 2'd0, 1'b0, 0, 8'd0,  8'd240};
      vt[11] = '{"jmp_p5",     sop(6, 5),   8'h80, 1'b0, 2'd0, 1'b0, 0, 8'd0,  8'd5};

      // Reset values, asserted then released.
      cycle();
      chk("rst_held", {pc, halted, cycle_cnt, bus.imem_req, bus.dmem_req, bus.dmem_we,
                       acc_we, rf_we, acc_sel, imm_out, op_ctrl, rf_addr}, 64'd0);
      do_reset();
      run_cycles(3);
      chk("idle_no_start", {bus.imem_req, pc, halted}, 64'd0);

      // Single-instruction vector table.
      for (int i = 0; i < 12; i++) begin
         do_reset(); fill_halt();
         imem[0] = vt[i].inst; acc_in = vt[i].acc;
         pulse_start(); cycle(); cycle();
         chk({vt[i].name, "_we"}, {acc_we, rf_we}, {vt[i].acc_we, vt[i].rf_we});
         if (vt[i].acc_we) chk({vt[i].name, "_sel"}, acc_sel, vt[i].sel);
         case (vt[i].kind)
            1: chk({vt[i].name, "_imm"}, imm_out, vt[i].val);
            2: chk({vt[i].name, "_op_rf"}, {op_ctrl, rf_addr}, vt[i].val);
            3: chk({vt[i].name, "_rf"}, rf_addr, vt[i].val[4:0]);
            default: ;
         endcase
         cycle();
         chk({vt[i].name, "_pc"}, {bus.imem_req, bus.imem_addr, pc}, {1'b1, vt[i].pc_nx, vt[i].pc_nx});
      end

      // LDI 5 / ADD r3 / HALT, zero-wait.
      do_reset(); fill_halt();
      imem[0] = sop(1, 5); imem[1] = alu(0, 3); imem[2] = sop(7, 0);
      pulse_start(); run_cycles(2);
      chk("prog_c3", {acc_we, acc_sel, imm_out}, {1'b1, 2'd1, 8'd5});
      cycle();
      chk("prog_c4", {acc_we, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, 8'd1});
      run_cycles(2);
      chk("prog_c6", {acc_we, acc_sel, op_ctrl, rf_addr}, {1'b1, 2'd0, 3'd0, 5'd3});
      run_cycles(3);
      chk("prog_c9", halted, 1'b0);
      cycle();
      chk("prog_halt", {halted, pc}, {1'b1, 8'd2});
      chk("prog_cnt", cycle_cnt, CNT_EN ? 16'd9 : 16'd0);
      spur = 1'b1; run_cycles(6); spur = 1'b0; cycle();
      chk("halt_ignores_ack", {halted, pc, bus.imem_req, bus.dmem_req, acc_we}, {1'b1, 8'd2, 3'b000});
      pulse_start();
      chk("restart", {halted, pc, bus.imem_req, bus.imem_addr}, {1'b0, 8'd0, 1'b1, 8'd0});

      // NOP / HALT cycle count.
      do_reset(); fill_halt();
      imem[0] = sop(0, 0); imem[1] = sop(7, 0);
      pulse_start();
      chk("cnt_c1", cycle_cnt, 16'd0);
      run_cycles(2);
      chk("cnt_c3", cycle_cnt, CNT_EN ? 16'd2 : 16'd0);
      run_cycles(4);
      chk("cnt_halted", {halted, cycle_cnt}, {1'b1, CNT_EN ? 16'd6 : 16'd0});
      run_cycles(3);
      chk("cnt_frozen", cycle_cnt, CNT_EN ? 16'd6 : 16'd0);

      // LD r7 with three wait cycles; start pulsed mid-MEM must be ignored.
      do_reset(); fill_halt();
      imem[0] = sop(3, 7); dmem_delay = 3;
      pulse_start(); run_cycles(2);
      chk("ld_c3", {bus.dmem_req, acc_we}, 2'b00);
      nreq = 0;
      for (int c = 4; c <= 8; c++) begin
         cycle();
         start = (c == 5);
         nreq += int'(bus.dmem_req);
         chk($sformatf("ld_c%0d", c), {bus.dmem_req, bus.dmem_we, acc_we}, {c <= 7, 1'b0, c == 7});
         if (c == 7) chk("ld_ack_sel", {acc_sel, rf_addr}, {2'd2, 5'd7});
      end
      start = 1'b0;
      chk("ld_req_cycles", nreq, 4);
      chk("ld_next_fetch", {bus.imem_req, bus.imem_addr}, {1'b1, 8'd1});

      // Instruction fetch held off for five cycles.
      do_reset(); fill_halt();
      imem[0] = alu(1, 4); imem_delay = 5;
      pulse_start();
      for (int c = 1; c <= 8; c++) begin
         if (c <= 6)
            chk($sformatf("fetch_wait_c%0d", c), {bus.imem_req, bus.imem_addr, acc_we}, {1'b1, 8'd0, 1'b0});
         else if (c == 7)
            chk("fetch_decode_c7", {bus.imem_req, acc_we}, 2'b00);
         else
            chk("fetch_exec_c8", {acc_we, op_ctrl, rf_addr}, {1'b1, 3'd1, 5'd4});
         cycle();
      end

      // Reset asserted while an ST waits in MEM.
      do_reset(); fill_halt();
      imem[0] = sop(0, 0); imem[1] = sop(0, 0); imem[2] = sop(0, 0); imem[3] = sop(4, 4);
      dmem_delay = 20;
      pulse_start(); run_cycles(12);
      chk("st_in_mem", {bus.dmem_req, bus.dmem_we, pc}, {1'b1, 1'b1, 8'd3});
      reset = 1'b1;
      #1;
      chk("st_async_rst", {bus.dmem_req, bus.dmem_we, pc, halted, bus.imem_req}, 64'd0);
      cycle(); reset = 1'b0; run_cycles(3);
      chk("st_rst_idle", {bus.imem_req, bus.dmem_req, pc}, 64'd0);

      // Random programs against the interpreter.
      for (int p = 0; p < 25; p++) begin
         do_reset();
         for (int a = 0; a < 256; a++) imem[a] = 9'($urandom);
         acc_in = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 255));
         imem_delay = $urandom_range(0, 2); dmem_delay = $urandom_range(0, 3);
         spur = 1'($urandom_range(0, 1));
         model(acc_in);
         nobs = 0; open = 1'b0; timed_out = 1'b1;
         start = 1'b1;
         for (int c = 0; c < 600; c++) begin
            cycle();
            start = 1'b0;
            if (bus.imem_req && bus.imem_ack) begin
               if (open) begin
                  if (nobs - 1 < exp_q.size()) chk($sformatf("rnd%0d_i%0d", p, nobs - 1), cur, exp_q[nobs - 1]);
                  open = 1'b0;
               end
               if (nobs == LIMIT) begin timed_out = 1'b0; break; end
               cur = '0; cur.addr = bus.imem_addr; open = 1'b1; nobs++;
            end
            if (acc_we) begin
               cur.nacc++; cur.sel = acc_sel;
               case (acc_sel)
                  2'd0:    cur.pay = {op_ctrl, rf_addr};
                  2'd1:    cur.pay = imm_out;
                  default: cur.pay = {3'b0, rf_addr};
               endcase
            end
            if (rf_we) begin cur.nrf++; cur.pay = {3'b0, rf_addr}; end
            if (bus.dmem_req && bus.dmem_ack) begin
               if (bus.dmem_we) cur.nst++; else cur.nld++;
            end
            if (halted) begin
               if (open && nobs - 1 < exp_q.size()) chk($sformatf("rnd%0d_i%0d", p, nobs - 1), cur, exp_q[nobs - 1]);
               open = 1'b0; timed_out = 1'b0;
               break;
            end
         end
         start = 1'b0; spur = 1'b0;
         chk($sformatf("rnd%0d_timeout", p), timed_out, 1'b0);
         chk($sformatf("rnd%0d_count", p), nobs, exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_seq.md
DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle pulse; begins execution from pc 0 when IDLE or HALT.
REQ-004 SHALL have ports imem_req output 1, imem_addr output 8, imem_ack input 1, imem_data input 9  instruction-fetch handshake.
REQ-005 SHALL have ports dmem_req output 1, dmem_we output 1, dmem_ack input 1  data-memory handshake; the address and data paths are outside this block.
REQ-006 SHALL have port acc_in  input  8  current accumulator value, used for the BZ test.
REQ-007 SHALL have ports op_ctrl output 3, rf_addr output 5, rf_we output 1, acc_we output 1, acc_sel output 2 (0=ALU, 1=IMM, 2=MEM), imm_out output 8  datapath control.
REQ-008 SHALL have ports pc output 8, halted output 1, cycle_cnt output 16.

Function
REQ-009 SHALL decode 9-bit instructions as follows: inst[8]=0 is an ALU op with op_ctrl=inst[7:5] and rf_addr=inst[4:0].
REQ-010 SHALL decode inst[8]=1 using sub-op inst[7:5], with arg=inst[4:0]: 0 NOP, 1 LDI (imm_out = zero-extended arg), 2 MOVA (rf_addr=arg, rf_we), 3 LD (rf_addr=arg), 4 ST (rf_addr=arg), 5 BZ (signed 5-bit offset), 6 JMP (signed offset), 7 HALT.
REQ-011 SHALL implement an FSM with states IDLE, FETCH, DECODE, EXEC, MEM, HALT.
REQ-012 SHALL leave IDLE or HALT for FETCH on start, clearing pc to 0 and halted to 0.
REQ-013 In FETCH, SHALL hold imem_req=1 and imem_addr=pc until the cycle imem_ack=1; it SHALL latch imem_data on that cycle and go to DECODE.
REQ-014 SHALL spend exactly one cycle in DECODE, registering all control fields.
REQ-015 In EXEC, an ALU op or LDI SHALL assert acc_we for exactly one cycle, with acc_sel=0 or 1 respectively; MOVA SHALL assert rf_we for one cycle.
REQ-016 In EXEC, LD and ST SHALL go to MEM.
REQ-017 In MEM, SHALL hold dmem_req=1 (dmem_we=1 for ST) until dmem_ack; for LD it SHALL assert acc_we with acc_sel=2 on the ack cycle only.
REQ-018 After EXEC (or after MEM on ack), SHALL set pc to pc+1, or to pc+sext(arg) for JMP and for BZ when acc_in==0, and return to FETCH.
REQ-019 SHALL perform all pc arithmetic modulo 256 (wraps 255→0 and 0→255).
REQ-020 HALT SHALL enter HALT state with halted=1, leave pc unchanged, and ignore the ack inputs.
REQ-021 Zero-wait latency SHALL be 3 cycles per ALU/LDI/MOVA/branch instruction and 4 cycles per LD/ST.
REQ-022 Outside their defined cycles, imem_req, dmem_req, dmem_we, acc_we and rf_we SHALL be 0.
REQ-023 SHALL ignore start while in FETCH, DECODE, EXEC or MEM.
REQ-024 SHALL ignore an ack arriving while the corresponding req is 0.

Reset
REQ-025 Reset SHALL force state IDLE, pc=0, halted=0, cycle_cnt=0, latched instruction=NOP, and all control outputs to 0, asynchronously and regardless of any in-flight handshake.
REQ-026 After reset deasserts, SHALL remain in IDLE until start.

Configuration
REQ-027 With CYCLE_COUNT_EN defined, cycle_cnt SHALL clear on start, increment every cycle outside IDLE and HALT, and saturate at 16'hFFFF.
REQ-028 Without CYCLE_COUNT_EN, cycle_cnt SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-029 The shared definitions package SHALL hold the Seq_State enum, the Sub_Ops enum, the acc_sel encodings, and the NOP instruction constant; ALU_Ops SHALL be reused unchanged for op_ctrl.
REQ-030 Decoding SHALL live in a combinational sub-module inst_decode, instantiated once; the FSM, pc and counter stay in decode_seq.

Verification
REQ-031 Reset, start, imem_ack tied 1, program {LDI 5, ALU Add r3, HALT} -> acc_we with acc_sel=1 and imm_out=8'd5 at cycle 3; op_ctrl=Add, rf_addr=3, acc_we at cycle 6; halted=1 with pc=2.
REQ-032 BZ offset -2 at pc=0 with acc_in=0 -> pc becomes 254; repeated with acc_in=8'h01 -> pc becomes 1.
REQ-033 LD r7 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, acc_we only on the ack cycle, dmem_we=0 throughout.
REQ-034 imem_ack held low for 5 cycles in FETCH -> imem_req and imem_addr stable; no decode until ack.
REQ-035 reset asserted mid-MEM during an ST -> dmem_req and dmem_we drop immediately; IDLE, pc=0.
REQ-036 CYCLE_COUNT_EN defined, zero-wait program {NOP, HALT} -> cycle_cnt=6 once halted; CYCLE_COUNT_EN undefined -> cycle_cnt=0.
